// File: rtl/rgb_mixer_core_if.sv
// Wishbone slave bundle between the Caravel wrapper and the RGB mixer core.
// Signal names follow the wrapper's wbs_* port names so the hookup reads one-to-one.
interface rgb_mixer_core_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_adr_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      output wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/rgb_mixer_core.sv
// Three-channel RGB mixer: debounced quadrature encoders adjust saturating 8-bit values,
// each value drives a PWM output, and all three are accessible over Wishbone.
module rgb_mixer_core #(
   parameter int          DEBOUNCE_BITS = 8,
   parameter logic [31:0] ID_WORD       = 32'h5247_4231
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_ni,
   rgb_mixer_core_if.slave   wb,
   input  logic [2:0]        enc_a,
   input  logic [2:0]        enc_b,
   output logic [2:0]        pwm_o,
   output logic [23:0]       value_o
);

   localparam logic [DEBOUNCE_BITS-1:0] PRESC_ONE = {{(DEBOUNCE_BITS-1){1'b0}}, 1'b1};

   logic [DEBOUNCE_BITS-1:0] presc;
   logic                     strobe;
   logic [2:0]               a_s1, a_s2, b_s1, b_s2;
   logic [2:0][2:0]          a_hist, b_hist, a_nxt, b_nxt;
   logic [2:0]               a_deb, b_deb, a_deb_q;
   logic [2:0]               step;
   logic [2:0]               wr_hit;
   logic [2:0][7:0]          val;
   logic [7:0]               cnt;
   logic                     req;
   logic [1:0]               idx;
   logic [31:0]              rd_mux;
   logic                     unused_ok;

   assign strobe  = &presc;
   assign req     = wb.wbs_stb_i & wb.wbs_cyc_i & ~wb.wbs_ack_o;
   assign idx     = wb.wbs_adr_i[3:2];
   assign step    = a_deb & ~a_deb_q;
   assign value_o = {val[2], val[1], val[0]};
   assign unused_ok = ^{wb.wbs_sel_i[3:1], wb.wbs_dat_i[31:8],
                        wb.wbs_adr_i[31:4], wb.wbs_adr_i[1:0]};

   always_comb begin
      a_nxt  = '0;
      b_nxt  = '0;
      wr_hit = '0;
      for (int i = 0; i < 3; i++) begin
         a_nxt[i]  = {a_hist[i][1:0], a_s2[i]};
         b_nxt[i]  = {b_hist[i][1:0], b_s2[i]};
         wr_hit[i] = req & wb.wbs_we_i & wb.wbs_sel_i[0] & (idx == 2'(i));
      end
   end

   always_comb begin
      rd_mux = ID_WORD;
      case (idx)
         2'd0:    rd_mux = {24'b0, val[0]};
         2'd1:    rd_mux = {24'b0, val[1]};
         2'd2:    rd_mux = {24'b0, val[2]};
         default: rd_mux = ID_WORD;
      endcase
   end

   // Debounced level flips only when the whole history agrees on the opposite level.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         presc   <= '0;
         a_s1    <= '0;
         a_s2    <= '0;
         b_s1    <= '0;
         b_s2    <= '0;
         a_hist  <= '0;
         b_hist  <= '0;
         a_deb   <= '0;
         b_deb   <= '0;
         a_deb_q <= '0;
      end else begin
         presc   <= presc + PRESC_ONE;
         a_s1    <= enc_a;
         a_s2    <= a_s1;
         b_s1    <= enc_b;
         b_s2    <= b_s1;
         a_deb_q <= a_deb;
         if (strobe) begin
            a_hist <= a_nxt;
            b_hist <= b_nxt;
            for (int i = 0; i < 3; i++) begin
               if (a_nxt[i] == {3{~a_deb[i]}}) a_deb[i] <= ~a_deb[i];
               if (b_nxt[i] == {3{~b_deb[i]}}) b_deb[i] <= ~b_deb[i];
            end
         end
      end
   end

   // A bus write to a channel overrides an encoder step landing in the same clock.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         val <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (wr_hit[i]) begin
               val[i] <= wb.wbs_dat_i[7:0];
            end else if (step[i]) begin
               if (!b_deb[i]) begin
                  if (val[i] != 8'hff) val[i] <= val[i] + 8'd1;
               end else begin
                  if (val[i] != 8'h00) val[i] <= val[i] - 8'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         wb.wbs_ack_o <= 1'b0;
         wb.wbs_dat_o <= '0;
      end else begin
         wb.wbs_ack_o <= req;
         if (req && !wb.wbs_we_i) wb.wbs_dat_o <= rd_mux;
         else                     wb.wbs_dat_o <= '0;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         cnt   <= '0;
         pwm_o <= '0;
      end else begin
         cnt <= cnt + 8'd1;
         for (int i = 0; i < 3; i++) pwm_o[i] <= (cnt < val[i]);
      end
   end

endmodule

// File: tb/tb_rgb_mixer_core.sv
// Bench for rgb_mixer_core with a short debounce prescaler; bus reads are scoreboarded
// and encoder/bus effects are tracked in a per-channel value model.
module tb_rgb_mixer_core;

   typedef struct {
      logic        is_read;
      logic [31:0] data;
   } sb_entry_t;

   logic        clk;
   logic        rst_n;
   logic [2:0]  enc_a, enc_b;
   logic [2:0]  pwm;
   logic [23:0] value;
   int          cyc;
   int          n_chk, n_pass;
   logic [7:0]  m [3];
   sb_entry_t   sb [$];

   rgb_mixer_core_if bus ();

   rgb_mixer_core #(.DEBOUNCE_BITS(2), .ID_WORD(32'h5247_4231)) dut (
      .wb_clk_i  (clk),
      .wb_rst_ni (rst_n),
      .wb        (bus),
      .enc_a     (enc_a),
      .enc_b     (enc_b),
      .pwm_o     (pwm),
      .value_o   (value)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_clk(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   function automatic logic [31:0] model_word();
      return {8'h00, m[2], m[1], m[0]};
   endfunction

   task automatic hold_phase();
      wait_clk(20);
   endtask

   // One full quadrature cycle on a channel; up = B low when A rises.
   task automatic quad_cycle(input int ch, input bit up);
      if (up) begin
         enc_a[ch] = 1'b1; hold_phase();
         enc_b[ch] = 1'b1; hold_phase();
         enc_a[ch] = 1'b0; hold_phase();
         enc_b[ch] = 1'b0; hold_phase();
         if (m[ch] != 8'hff) m[ch] = m[ch] + 8'd1;
      end else begin
         enc_b[ch] = 1'b1; hold_phase();
         enc_a[ch] = 1'b1; hold_phase();
         enc_b[ch] = 1'b0; hold_phase();
         enc_a[ch] = 1'b0; hold_phase();
         if (m[ch] != 8'h00) m[ch] = m[ch] - 8'd1;
      end
   endtask

   // Called #1 after a clock edge; the request is sampled on the next edge.
   task automatic wb_xfer(input string tag, input logic we, input logic [1:0] idx,
                          input logic [31:0] dat, input logic [3:0] sel,
                          input logic [31:0] exp_rd);
      sb_entry_t e;
      int        waited;
      sb.push_back('{is_read: ~we, data: exp_rd});
      bus.wbs_stb_i = 1'b1;
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_we_i  = we;
      bus.wbs_sel_i = sel;
      bus.wbs_dat_i = dat;
      bus.wbs_adr_i = {28'h0, idx, 2'b00};
      tick();
      waited = 1;
      while (!bus.wbs_ack_o && waited < 8) begin
         tick();
         waited++;
      end
      check_val({tag, "_ack_lat"}, waited, 1);
      e = sb.pop_front();
      if (bus.wbs_ack_o && e.is_read) check_val({tag, "_rdata"}, bus.wbs_dat_o, e.data);
      bus.wbs_stb_i = 1'b0;
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      tick();
      check_val({tag, "_ack_drop"}, {31'b0, bus.wbs_ack_o}, 32'd0);
      check_val({tag, "_dat_clr"}, bus.wbs_dat_o, 32'd0);
   endtask

   task automatic pwm_count(input int ch, output int highs);
      highs = 0;
      for (int k = 0; k < 256; k++) begin
         @(negedge clk);
         if (pwm[ch]) highs++;
      end
   endtask

   initial begin
      int c;
      int highs;
      n_chk = 0;
      n_pass = 0;
      for (int i = 0; i < 3; i++) m[i] = 8'h00;
      rst_n = 1'b0;
      enc_a = '0;
      enc_b = '0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      bus.wbs_sel_i = '0;
      bus.wbs_dat_i = '0;
      bus.wbs_adr_i = '0;

      // Reset with encoders toggling
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         enc_a = 3'($urandom);
         enc_b = 3'($urandom);
         @(negedge clk);
         check_val("rst_value", {8'h0, value}, 32'd0);
         check_val("rst_pwm_ack", {28'h0, pwm, bus.wbs_ack_o}, 32'd0);
      end
      enc_a = '0;
      enc_b = '0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      check_val("post_rst_value", {8'h0, value}, 32'd0);
      check_val("post_rst_pwm_ack", {28'h0, pwm, bus.wbs_ack_o}, 32'd0);
      wait_clk(10);

      // Channel 0 up then down past zero
      for (int k = 0; k < 5; k++) begin
         quad_cycle(0, 1'b1);
         check_val("enc0_up", {8'h0, value}, model_word());
      end
      check_val("enc0_is5", {24'h0, value[7:0]}, 32'd5);
      for (int k = 0; k < 7; k++) begin
         quad_cycle(0, 1'b0);
         check_val("enc0_down", {8'h0, value}, model_word());
      end
      check_val("enc0_sat0", {24'h0, value[7:0]}, 32'd0);

      // Short glitch on channel 1 is filtered, clean cycle counts
      enc_a[1] = 1'b1;
      wait_clk(6);
      enc_a[1] = 1'b0;
      wait_clk(40);
      check_val("glitch_ch1", {8'h0, value}, model_word());
      quad_cycle(1, 1'b1);
      check_val("clean_ch1", {24'h0, value[15:8]}, 32'd1);

      // Wishbone access
      wb_xfer("wr_idx2", 1'b1, 2'd2, 32'h0000_00c8, 4'b0001, 32'h0);
      m[2] = 8'hc8;
      check_val("wr_idx2_val", {8'h0, value}, model_word());
      wb_xfer("rd_idx2", 1'b0, 2'd2, 32'h0, 4'b1111, 32'h0000_00c8);
      wb_xfer("rd_idx3", 1'b0, 2'd3, 32'h0, 4'b1111, 32'h5247_4231);
      wb_xfer("wr_sel1", 1'b1, 2'd2, 32'h0000_3333, 4'b0010, 32'h0);
      check_val("wr_sel1_val", {8'h0, value}, model_word());
      wb_xfer("rd_idx2b", 1'b0, 2'd2, 32'h0, 4'b1111, {24'h0, m[2]});
      wb_xfer("wr_idx3", 1'b1, 2'd3, 32'h0000_00aa, 4'b0001, 32'h0);
      check_val("wr_idx3_val", {8'h0, value}, model_word());
      wb_xfer("rd_idx1", 1'b0, 2'd1, 32'h0, 4'b0001, {24'h0, m[1]});

      // PWM duty
      wb_xfer("wr_pwm64", 1'b1, 2'd0, 32'd64, 4'b0001, 32'h0);
      m[0] = 8'd64;
      wait_clk(2);
      pwm_count(0, highs);
      check_val("pwm_64", highs, 64);
      tick();
      wb_xfer("wr_pwm255", 1'b1, 2'd0, 32'd255, 4'b0001, 32'h0);
      m[0] = 8'd255;
      wait_clk(2);
      pwm_count(0, highs);
      check_val("pwm_255", highs, 255);
      tick();
      wb_xfer("wr_pwm0", 1'b1, 2'd0, 32'd0, 4'b0001, 32'h0);
      m[0] = 8'd0;
      wait_clk(2);
      pwm_count(0, highs);
      check_val("pwm_0", highs, 0);
      check_val("pwm_model", {8'h0, value}, model_word());

      // Collision: the debounced step on channels 1 and 2 lands 12 edges after an
      // A-edge driven just after an edge with cyc%4==1 (strobes at cyc%4==0).
      tick();
      while (cyc % 4 != 1) tick();
      c = cyc;
      enc_a[1] = 1'b1;
      enc_a[2] = 1'b1;
      while (cyc != c + 11) tick();
      wb_xfer("collide_wr", 1'b1, 2'd1, 32'h0000_0010, 4'b0001, 32'h0);
      m[1] = 8'h10;
      m[2] = m[2] + 8'd1;
      check_val("collide_ch1", {24'h0, value[15:8]}, 32'h10);
      check_val("collide_ch2", {24'h0, value[23:16]}, {24'h0, m[2]});
      enc_a[1] = 1'b0;
      enc_a[2] = 1'b0;
      wait_clk(30);
      check_val("collide_final", {8'h0, value}, model_word());

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/rgb_mixer_core.md
Name: rgb_mixer_core

Overview:
Three-channel RGB mixer core instantiated directly inside the project's tristating wrapper. It feeds that wrapper's Wishbone ack/data and io_out signals.
- Each channel debounces a rotary quadrature encoder and keeps an 8-bit colour value that is adjusted by rotation.
- Each channel drives one PWM output from its value.
- The three values can be read and written over the Caravel Wishbone slave port.

Parameters:
DEBOUNCE_BITS, 8, prescaler width; debounce sample strobe every 2^DEBOUNCE_BITS clocks
ID_WORD, 32'h5247_4231, constant returned at register index 3

Ports:
wb_clk_i  input  1  single system clock, all logic rising-edge
wb_rst_ni  input  1  synchronous reset, active-low
wbs_stb_i  input  1  Wishbone strobe
wbs_cyc_i  input  1  Wishbone cycle
wbs_we_i  input  1  Wishbone write enable
wbs_sel_i  input  4  Wishbone byte selects
wbs_dat_i  input  32  Wishbone write data
wbs_adr_i  input  32  Wishbone address; only [3:2] decoded
wbs_ack_o  output  1  Wishbone acknowledge
wbs_dat_o  output  32  Wishbone read data
enc_a  input  3  encoder A phase, bit i = channel i (0=R, 1=G, 2=B), asynchronous
enc_b  input  3  encoder B phase, same mapping, asynchronous
pwm_o  output  3  PWM outputs, bit i = channel i
value_o  output  24  {value2, value1, value0}, for logic-analyser observation

Behaviour:
Reset and clocking:
- Single clock wb_clk_i. Reset is synchronous, active-low: sampled on the clock edge while wb_rst_ni==0.
- Reset values: value0..2=0, pwm_o=0, wbs_ack_o=0, wbs_dat_o=0, value_o=0.
- Also cleared at reset: prescaler, PWM counter, synchronisers, sample shift registers, debounced levels.
- Reset asserted mid-transaction drops ack and discards any pending write.

Input synchronisation:
- Each enc_a/enc_b bit passes through a 2-flop synchroniser.

Debounce:
- Free-running DEBOUNCE_BITS prescaler; strobe is one clock wide when prescaler == all-ones.
- On each strobe, shift the synchronised level into a 3-bit history per signal.
- The debounced level takes the new level only when all 3 history bits are equal and differ from the current debounced level.

Quadrature decode (per channel):
- A step is a debounced-A rising edge (previous 0, current 1).
- Step with debounced B==0 increments the value; with B==1 decrements it.
- Debounced-A falling edges and B edges cause no change.
- Arithmetic saturates: increment at 255 holds 255; decrement at 0 holds 0. No wrap-around.
- The value updates the clock after the debounced-A edge is detected.

PWM:
- Shared free-running 8-bit counter; 0..255 wrap, period 256 clocks.
- pwm_o[i] registered: pwm_o[i] <= (cnt < value_i).
- Value 0 gives a constant-low output; value 255 gives high for 255 of 256 clocks.
- A new value takes effect on the next clock; there is no period-boundary shadowing.

Wishbone:
- Request = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o.
- On a request, wbs_ack_o is 1 the following clock for exactly one cycle. Back-to-back requests therefore ack at most every other clock.
- Address index = wbs_adr_i[3:2]: 0 = value0, 1 = value1, 2 = value2, 3 = ID_WORD (read-only).
- Read: wbs_dat_o is registered with ack; it is {24'b0, value_i} for index 0-2, ID_WORD for index 3.
- wbs_dat_o returns to 0 on the clock after ack.
- Write: when wbs_we_i & wbs_sel_i[0], value_i <= wbs_dat_i[7:0] on the request clock.
- Writes to index 3, or writes with sel[0]=0, are acked and ignored.

Simultaneous events:
- A Wishbone write and an encoder step to the same channel in the same clock: the write wins and the step is discarded.
- Steps on different channels in the same clock are all applied.

value_o:
- Continuously mirrors the three value registers.

Test Plan:
(Bench uses DEBOUNCE_BITS=2.)
1. Reset: hold wb_rst_ni low 4 clocks with encoders toggling -> value_o=0, pwm_o=0, wbs_ack_o=0 throughout and on the first clock after release.
2. Encoder, channel 0: apply 5 clean quadrature cycles with B low at A rising, each phase held 20 clocks -> value0=5. Then 7 cycles with B high at A rising -> value0=0; saturation holds it at 0 with no wrap to 255.
3. Debounce: glitch enc_a[1] high for 6 clocks (less than 3 strobes) -> value1 unchanged. A clean edge held 20 clocks -> value1 increments by 1.
4. Wishbone: write 0x000000C8 to index 2 with sel=4'b0001 -> ack one cycle later for one cycle; read index 2 returns 0x000000C8; read index 3 returns 0x52474231. Write with sel=4'b0010 -> ack received, value unchanged.
5. PWM: write value0=64 -> over 256 clocks pwm_o[0] is high for exactly 64 clocks. value0=255 -> high for 255 clocks. value0=0 -> never high.
6. Collision: Wishbone write of 0x10 to index 1 in the same clock as an increment step on channel 1 -> value1=0x10. Channel 2 stepping in that same clock still increments.
